// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the MM:SS countdown sequencer.
//   state_t   : FSM state encoding (Idle=0, Run=1, Pause=2, Done=3)
//   MaxMin    : largest loadable minute value
//   MaxSec    : largest loadable second value
//   sat_min   : clamp a raw minute preset to MaxMin
//   sat_sec   : clamp a raw second preset to MaxSec
//   dec_mmss  : one-second decrement of an MM:SS pair, sticking at 00:00
package countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_t;

    localparam int unsigned MaxMin = 99;
    localparam int unsigned MaxSec = 59;

    function automatic logic [6:0] sat_min(input logic [6:0] m);
        return (m > 7'(MaxMin)) ? 7'(MaxMin) : m;
    endfunction

    function automatic logic [5:0] sat_sec(input logic [5:0] s);
        return (s > 6'(MaxSec)) ? 6'(MaxSec) : s;
    endfunction

    // Result is {min, sec}. Borrowing from minutes reloads seconds with 59.
    function automatic logic [12:0] dec_mmss(input logic [6:0] m, input logic [5:0] s);
        logic [12:0] r;
        if (s != 6'd0) begin
            r = {m, s - 6'd1};
        end else if (m != 7'd0) begin
            r = {m - 7'd1, 6'(MaxSec)};
        end else begin
            r = {m, s};
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Enable-gated prescaler producing a one-cycle strobe every TICK_DIV enabled cycles.
// Ports:
//   clock_25 in  system clock
//   reset    in  asynchronous active-low reset
//   en       in  count enable; the count holds while low
//   clr      in  synchronous clear, overrides en
//   tick     out high in the enabled cycle whose count is TICK_DIV-1
module countdown_ctrl_tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic clock_25,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == LastCnt) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Depends only on registered state, so the strobe is glitch-free downstream.
    assign tick = en && (cnt_q == LastCnt);

endmodule

// File: rtl/countdown_ctrl.sv
// Sequencer for the MM:SS countdown timer, single 25 MHz clock domain.
// Loads a saturated preset, counts it down once per prescaler tick under
// start/pause/clear control, then raises done and a time-limited alarm.
// Ports:
//   clock_25 in   system clock
//   reset    in   asynchronous active-low reset
//   start    in   pulse: start from Idle/Done, resume from Pause
//   pause    in   pulse: freeze countdown (Run only)
//   clear    in   pulse: abort to Idle (highest priority)
//   load_min in 7 preset minutes (>99 saturates)
//   load_sec in 6 preset seconds (>59 saturates)
//   min_out  out 7 remaining minutes
//   sec_out  out 6 remaining seconds
//   running  out  high in Run
//   paused   out  high in Pause
//   done     out  high in Done
//   alarm    out  high for ALARM_LEN ticks after entering Done
//   tick     out  prescaler strobe, only visible in Run
module countdown_ctrl #(
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter int unsigned CNT_W     = 25,
    parameter int unsigned ALARM_LEN = 3
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [6:0] load_min,
    input  logic [5:0] load_sec,
    output logic [6:0] min_out,
    output logic [5:0] sec_out,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       alarm,
    output logic       tick
);

    import countdown_ctrl_pkg::*;

    localparam int unsigned AlarmW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
    localparam logic [AlarmW-1:0] AlarmLast = AlarmW'(ALARM_LEN - 1);

    state_t            state_q;
    logic [6:0]        min_q;
    logic [5:0]        sec_q;
    logic              alarm_q;
    logic [AlarmW-1:0] alarm_cnt_q;

    logic        presc_en;
    logic        presc_clr;
    logic        presc_tick;
    logic        load_req;
    logic        preset_zero;
    logic        at_last_sec;
    logic [6:0]  preset_min;
    logic [5:0]  preset_sec;
    logic [12:0] dec_val;

    assign preset_min  = sat_min(load_min);
    assign preset_sec  = sat_sec(load_sec);
    assign preset_zero = (preset_min == 7'd0) && (preset_sec == 6'd0);
    assign at_last_sec = (min_q == 7'd0) && (sec_q == 6'd1);
    assign dec_val     = dec_mmss(min_q, sec_q);

    // A fresh load happens on start from Idle or Done; resume from Pause keeps the phase.
    assign load_req  = start && !clear && ((state_q == StIdle) || (state_q == StDone));

    // The prescaler also runs in Done so the alarm can be timed in whole seconds.
    assign presc_en  = (state_q == StRun) || (state_q == StDone);
    assign presc_clr = clear || load_req;

    countdown_ctrl_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clock_25 (clock_25),
        .reset    (reset),
        .en       (presc_en),
        .clr      (presc_clr),
        .tick     (presc_tick)
    );

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            min_q       <= '0;
            sec_q       <= '0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else if (clear) begin
            state_q     <= StIdle;
            min_q       <= '0;
            sec_q       <= '0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        min_q       <= preset_min;
                        sec_q       <= preset_sec;
                        alarm_cnt_q <= '0;
                        if (preset_zero) begin
                            state_q <= StDone;
                            alarm_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            alarm_q <= 1'b0;
                        end
                    end else if ((state_q == StDone) && alarm_q && presc_tick) begin
                        if (alarm_cnt_q == AlarmLast) begin
                            alarm_q     <= 1'b0;
                            alarm_cnt_q <= '0;
                        end else begin
                            alarm_cnt_q <= alarm_cnt_q + AlarmW'(1);
                        end
                    end
                end
                StRun: begin
                    // A tick coinciding with pause still takes its step; pause then applies.
                    if (presc_tick) begin
                        if (at_last_sec) begin
                            state_q     <= StDone;
                            min_q       <= '0;
                            sec_q       <= '0;
                            alarm_q     <= 1'b1;
                            alarm_cnt_q <= '0;
                        end else begin
                            {min_q, sec_q} <= dec_val;
                            if (pause) begin
                                state_q <= StPause;
                            end
                        end
                    end else if (pause) begin
                        state_q <= StPause;
                    end
                end
                StPause: begin
                    if (start) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign min_out = min_q;
    assign sec_out = sec_q;
    assign running = (state_q == StRun);
    assign paused  = (state_q == StPause);
    assign done    = (state_q == StDone);
    assign alarm   = alarm_q;
    assign tick    = presc_tick && (state_q == StRun);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed literal checks plus random stimulus compared
// every cycle against a total-seconds behavioural model.
module tb_countdown_ctrl;

    localparam int DIV  = 4;
    localparam int ALEN = 3;

    logic       clock_25 = 1'b0;
    logic       reset    = 1'b0;
    logic       start    = 1'b0;
    logic       pause    = 1'b0;
    logic       clear    = 1'b0;
    logic [6:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic [6:0] min_out;
    logic [5:0] sec_out;
    logic       running;
    logic       paused;
    logic       done;
    logic       alarm;
    logic       tick;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    countdown_ctrl #(
        .TICK_DIV  (DIV),
        .CNT_W     (3),
        .ALARM_LEN (ALEN)
    ) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .load_min (load_min),
        .load_sec (load_sec),
        .min_out  (min_out),
        .sec_out  (sec_out),
        .running  (running),
        .paused   (paused),
        .done     (done),
        .alarm    (alarm),
        .tick     (tick)
    );

    always #5 clock_25 = ~clock_25;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining time kept as total seconds, phase as cycles into a second.
    localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;
    int m_mode, m_rem, m_phase, m_alarm_left, old_mode;
    bit m_alarm, raw_tick;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            m_mode = MIdle; m_rem = 0; m_phase = 0; m_alarm = 0; m_alarm_left = 0;
        end else begin
            old_mode = m_mode;
            raw_tick = ((old_mode == MRun) || (old_mode == MDone)) && (m_phase == DIV - 1);
            if (clear) begin
                m_mode = MIdle; m_rem = 0; m_phase = 0; m_alarm = 0; m_alarm_left = 0;
            end else if (start && old_mode == MPause) begin
                m_mode = MRun;
            end else if (start && old_mode != MRun) begin
                m_rem = sat(int'(load_min), 99) * 60 + sat(int'(load_sec), 59);
                m_phase = 0;
                if (m_rem == 0) begin
                    m_mode = MDone; m_alarm = 1; m_alarm_left = ALEN;
                end else begin
                    m_mode = MRun; m_alarm = 0;
                end
            end else begin
                if (old_mode == MRun || old_mode == MDone) m_phase = (m_phase + 1) % DIV;
                if (old_mode == MRun) begin
                    if (raw_tick) begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin
                            m_mode = MDone; m_alarm = 1; m_alarm_left = ALEN;
                        end else if (pause) begin
                            m_mode = MPause;
                        end
                    end else if (pause) begin
                        m_mode = MPause;
                    end
                end else if (old_mode == MDone && raw_tick && m_alarm) begin
                    m_alarm_left = m_alarm_left - 1;
                    if (m_alarm_left == 0) m_alarm = 0;
                end
            end
        end
    end

    always @(negedge clock_25) begin
        if (chk_en) begin
            check("min_out", 32'(min_out), m_rem / 60);
            check("sec_out", 32'(sec_out), m_rem % 60);
            check("running", 32'(running), 32'(m_mode == MRun));
            check("paused", 32'(paused), 32'(m_mode == MPause));
            check("done", 32'(done), 32'(m_mode == MDone));
            check("alarm", 32'(alarm), 32'(m_alarm));
            check("tick", 32'(tick), 32'(m_mode == MRun && m_phase == DIV - 1));
        end
    end

    // Called at a negedge: holds the pulses for one sampling edge, returns at the next negedge.
    task automatic drive(input bit s, input bit p, input bit c);
        start = s; pause = p; clear = c;
        @(negedge clock_25);
        start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    // Number of negedges until tick is seen, bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clock_25);
            n++;
        end while (!tick && n < 50);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_min"}, 32'(min_out), 0);
        check({tag, "_sec"}, 32'(sec_out), 0);
        check({tag, "_flags"}, 32'({running, paused, done, alarm, tick}), 0);
    endtask

    initial begin
        int n;
        bit seen;
        repeat (3) @(negedge clock_25);
        check_all_zero("reset_state");
        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clock_25);

        // 00:03: first tick on the 4th cycle after the start edge, then every 4 cycles.
        load_min = 7'd0; load_sec = 6'd3;
        drive(1, 0, 0);
        check("t3_load_sec", 32'(sec_out), 3);
        check("t3_running", 32'(running), 1);
        wait_tick(n); check("t3_first_tick_wait", n, 3);
        @(negedge clock_25); check("t3_sec_2", 32'(sec_out), 2);
        wait_tick(n); check("t3_tick_period", n, 3);
        @(negedge clock_25); check("t3_sec_1", 32'(sec_out), 1);
        wait_tick(n);
        @(negedge clock_25);
        check("t3_sec_0", 32'(sec_out), 0);
        check("t3_done", 32'(done), 1);
        check("t3_alarm_on", 32'(alarm), 1);
        // Three more prescaler periods in Done, then alarm drops.
        repeat (11) @(negedge clock_25);
        check("t3_alarm_still_on", 32'(alarm), 1);
        @(negedge clock_25);
        check("t3_alarm_off", 32'(alarm), 0);
        check("t3_done_held", 32'(done), 1);

        // 01:00 borrows to 00:59 on the first tick.
        load_min = 7'd1; load_sec = 6'd0;
        drive(1, 0, 0);
        wait_tick(n);
        @(negedge clock_25);
        check("borrow_min", 32'(min_out), 0);
        check("borrow_sec", 32'(sec_out), 59);

        // 00:05: pause after one counted cycle leaves the phase at 2; resume ticks on cycle 2.
        drive(0, 0, 1);
        load_min = 7'd0; load_sec = 6'd5;
        drive(1, 0, 0);
        @(negedge clock_25);
        drive(0, 1, 0);
        check("pause_paused", 32'(paused), 1);
        repeat (20) @(negedge clock_25);
        check("pause_frozen_sec", 32'(sec_out), 5);
        check("pause_no_tick", 32'(tick), 0);
        drive(1, 0, 0);
        check("resume_running", 32'(running), 1);
        wait_tick(n); check("resume_tick_wait", n, 1);
        @(negedge clock_25); check("resume_sec_4", 32'(sec_out), 4);

        // 00:00 goes straight to Done with alarm; tick never shows.
        drive(0, 0, 1);
        load_min = 7'd0; load_sec = 6'd0;
        drive(1, 0, 0);
        check("zero_done", 32'(done), 1);
        check("zero_alarm", 32'(alarm), 1);
        check("zero_running", 32'(running), 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clock_25);
            seen |= tick;
        end
        check("zero_no_tick", 32'(seen), 0);

        // clear beats start; pause ignored in Idle; presets saturate.
        drive(0, 0, 1);
        load_min = 7'd0; load_sec = 6'd10;
        drive(1, 0, 0);
        repeat (2) @(negedge clock_25);
        drive(1, 0, 1);
        check("clr_start_idle", 32'({running, paused, done}), 0);
        check("clr_start_sec", 32'(sec_out), 0);
        drive(0, 1, 0);
        check("idle_pause_ignored", 32'(paused), 0);
        load_min = 7'd120; load_sec = 6'd63;
        drive(1, 0, 0);
        check("sat_min", 32'(min_out), 99);
        check("sat_sec", 32'(sec_out), 59);

        // Asynchronous reset mid-run at 00:02.
        drive(0, 0, 1);
        load_min = 7'd0; load_sec = 6'd3;
        drive(1, 0, 0);
        wait_tick(n);
        @(negedge clock_25);
        check("rst_pre_sec", 32'(sec_out), 2);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clock_25);
        reset = 1'b1;
        @(negedge clock_25);
        drive(1, 0, 0);
        check("rst_reload_sec", 32'(sec_out), 3);
        check("rst_reload_run", 32'(running), 1);

        // Random control traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                load_min = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127))
                                                        : 7'($urandom_range(0, 1));
                load_sec = 6'($urandom_range(0, 63));
            end
            start = ($urandom_range(0, 19) == 0);
            pause = ($urandom_range(0, 24) == 0);
            clear = ($urandom_range(0, 99) == 0);
            @(negedge clock_25);
        end
        start = 1'b0; pause = 1'b0; clear = 1'b0;
        @(negedge clock_25);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
